fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

    // One memory request may be outstanding; WAIT_DROP swallows a response made stale by a redirect.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWait     = 2'd1,
        StWaitDrop = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {instruction, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: one outstanding imem request, responses buffered for decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              grant, rsp_accept, head_valid;

    // Requesting only from IDLE with a free slot reserves room for the single outstanding response.
    assign imem_req   = !rst && (state_q == StIdle) && !redirect_valid
                        && (fifo_count < CntW'(DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign grant      = imem_req && imem_gnt;
    assign rsp_accept = !rst && (state_q == StWait) && imem_rvalid && !redirect_valid;
    assign head_valid = !rst && !fifo_empty;
    assign fifo_pop   = head_valid && inst_ready && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass    = rsp_accept && fifo_empty;
    assign fifo_push = rsp_accept && !(bypass && inst_ready);

    always_comb begin
        inst_valid = head_valid;
        inst       = INSTR_NOP;
        inst_pc    = '0;
        if (head_valid) begin
            inst    = fifo_head[2*XLEN-1:XLEN];
            inst_pc = fifo_head[XLEN-1:0];
        end else if (bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = req_pc_q;
        end
    end
`else
    assign fifo_push  = rsp_accept;
    assign inst_valid = head_valid;
    assign inst       = head_valid ? fifo_head[2*XLEN-1:XLEN] : INSTR_NOP;
    assign inst_pc    = head_valid ? fifo_head[XLEN-1:0] : '0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = pc_next(fetch_pc_q);
                    state_d    = StWait;
                end
            end
            StWait: begin
                // A response coinciding with a redirect completes the transaction; its data is dropped.
                if (imem_rvalid)         state_d = StIdle;
                else if (redirect_valid) state_d = StWaitDrop;
            end
            StWaitDrop: begin
                if (imem_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_pc & ~XLEN'(3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  ({imem_rdata, req_pc_q}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_push_has_slot: assert property (@(posedge clk) disable iff (rst) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed fetch, full, redirect and bypass scenarios.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int tests = 0;
    int fails = 0;

    // Expected {inst, pc} in the order decode should accept them.
    logic [63:0] exp_q[$];

    // Memory model state.
    int          budget    = 0;
    int          rsp_delay = 0;
    bit          pending   = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h00000000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h00000200) return 32'h00500093;
        return 32'hC0DE0000 | {16'h0000, addr[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Memory: grants while budget lasts, answers rsp_delay cycles after the grant cycle.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pending) begin
                if (pend_wait == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pending     = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            imem_gnt = (budget > 0);
            if (imem_req && imem_gnt) begin
                pending   = 1'b1;
                pend_addr = imem_addr;
                pend_wait = rsp_delay;
                budget--;
            end
        end
    end

    // Monitor: every decode handshake must match the next scoreboard entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, required no entry",
                             inst_pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_inst", inst, e[63:32]);
                    chk("pop_pc", inst_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("req_in_reset", imem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_req", imem_req, 1);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_valid", inst_valid, 0);
        chk("reset_inst", inst, 32'h00000013);
        chk("reset_pc", inst_pc, 32'h0);

        // Streaming with immediate grant and 1-cycle response
        @(negedge clk);
        inst_ready = 1'b1;
        budget     = 3;
        exp_q.push_back({32'hC0DE0000, 32'h00000000});
        exp_q.push_back({32'hC0DE0004, 32'h00000004});
        exp_q.push_back({32'hC0DE0008, 32'h00000008});
        wait_drain("stream_drain");
        #2;
        chk("stream_empty", inst_valid, 0);
        chk("stream_next_addr", imem_addr, 32'h0000000C);

        // Fill the queue with decode stalled
        @(negedge clk);
        rst        = 1'b1;
        inst_ready = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        budget = 5;
        exp_q.push_back({32'hC0DE0000, 32'h00000000});
        exp_q.push_back({32'hC0DE0004, 32'h00000004});
        exp_q.push_back({32'hC0DE0008, 32'h00000008});
        exp_q.push_back({32'hC0DE000C, 32'h0000000C});
        exp_q.push_back({32'hC0DE0010, 32'h00000010});
        repeat (12) @(negedge clk);
        #2;
        chk("full_req_low", imem_req, 0);
        chk("full_grants", budget, 1);
        chk("full_head_valid", inst_valid, 1);
        chk("full_head_pc", inst_pc, 32'h0);
        @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #2;
        chk("after_pop_req", imem_req, 1);
        chk("after_pop_addr", imem_addr, 32'h00000010);
        @(negedge clk);
        inst_ready = 1'b1;
        wait_drain("full_drain");

        // Redirect while a request is outstanding
        @(negedge clk);
        rsp_delay = 3;
        budget    = 1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000100;
        #2;
        chk("redirect_suppress_req", imem_req, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("drop_wait_req", imem_req, 0);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!imem_req && n < 10);
        rsp_delay = 0;
        chk("drop_resume_req", imem_req, 1);
        chk("drop_resume_addr", imem_addr, 32'h00000100);
        chk("drop_no_stale", inst_valid, 0);

        // Redirect coinciding with pop and a response
        @(negedge clk);
        inst_ready = 1'b0;
        budget     = 2;
        exp_q.push_back({32'hC0DE0100, 32'h00000100});
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000200;
        inst_ready     = 1'b1;
        #2;
        chk("coincide_head_valid", inst_valid, 1);
        chk("coincide_head_pc", inst_pc, 32'h00000100);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("coincide_empty", inst_valid, 0);
        chk("coincide_nop", inst, 32'h00000013);
        chk("coincide_pc", inst_pc, 32'h0);
        chk("coincide_addr", imem_addr, 32'h00000200);

        // Response latency to decode (zero with bypass, one without)
        @(negedge clk);
        budget = 1;
        exp_q.push_back({32'h00500093, 32'h00000200});
        @(negedge clk);
        #2;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("bypass_valid", inst_valid, 1);
        chk("bypass_inst", inst, 32'h00500093);
        @(negedge clk);
        #2;
        chk("bypass_no_write", inst_valid, 0);
`else
        chk("queued_not_yet", inst_valid, 0);
        @(negedge clk);
        #2;
        chk("queued_valid", inst_valid, 1);
        chk("queued_inst", inst, 32'h00500093);
        chk("queued_pc", inst_pc, 32'h00000200);
`endif
        wait_drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
